// File: rtl/ofdm_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_pkg
//   Shared definitions for the OFDM receive chain (Schmidl-Cox detector and
//   cyclic-prefix remover).
//
//   Contents:
//     OFDM_FFT_SIZE     default FFT / window length used across the chain
//     OFDM_CP_LEN       default cyclic-prefix length used across the chain
//     OFDM_MAX_CP_SIZE  default upper bound on a run-time cyclic-prefix length
//     cpr_state_t       state encoding of the CP remover
//     max_u / width_of  elaboration-time sizing helpers
// ----------------------------------------------------------------------------
package ofdm_pkg;

    localparam int unsigned OFDM_FFT_SIZE    = 1024;
    localparam int unsigned OFDM_CP_LEN      = 128;
    localparam int unsigned OFDM_MAX_CP_SIZE = 256;

    // KEEP: forwarding window samples
    // DROP: discarding the cyclic prefix between windows
    // PAD : zero-filling a window cut short by the end of a packet
    typedef enum logic [1:0] {
        KEEP = 2'd0,
        DROP = 2'd1,
        PAD  = 2'd2
    } cpr_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : ofdm_pkg

// File: rtl/ofdm_cp_remover.sv
// ----------------------------------------------------------------------------
// ofdm_cp_remover
//   Sits behind the Schmidl-Cox detector. The incoming gated stream starts at
//   mid-CP of the first OFDM symbol, so the first FFT_SIZE samples form the
//   first window. The stream is cut into FFT_SIZE-sample windows separated by
//   cp_len discarded samples. Each window leaves with tlast on its final
//   sample. A window cut short by the end of a packet is completed with zeros.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     clear             synchronous flush, identical effect to reset
//     cp_len[15:0]      CP samples removed between windows (clamped to MAX_CP_SIZE)
//     packet_length     input samples per packet, 0 = unbounded
//     i_t*              AXI-Stream sample input (i_tlast is not used)
//     o_t*              AXI-Stream window output, one register stage
//     pkt_done          single-cycle pulse when a packet is fully consumed/padded
//     sym_count[15:0]   windows emitted in the current packet, held until the
//                       next packet's first sample
// ----------------------------------------------------------------------------
module ofdm_cp_remover
    import ofdm_pkg::*;
#(
    parameter int unsigned FFT_SIZE    = OFDM_FFT_SIZE,
    parameter int unsigned MAX_CP_SIZE = OFDM_MAX_CP_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] cp_len,
    input  logic [31:0] packet_length,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        pkt_done,
    output logic [15:0] sym_count
);

    localparam int unsigned CNT_W = width_of(max_u(FFT_SIZE, MAX_CP_SIZE));
    localparam int unsigned CP_W  = width_of(MAX_CP_SIZE + 1);

    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(FFT_SIZE - 1);
    localparam logic [CP_W-1:0]  CP_MAX  = CP_W'(MAX_CP_SIZE);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    cpr_state_t       state_q,     state_d;
    logic [CNT_W-1:0] ph_cnt_q,    ph_cnt_d;
    logic [31:0]      in_cnt_q,    in_cnt_d;
    logic [15:0]      sym_count_q, sym_count_d;
    logic [CP_W-1:0]  cp_len_q,    cp_len_d;
    logic [31:0]      pkt_len_q,   pkt_len_d;
    logic [31:0]      o_tdata_q,   o_tdata_d;
    logic             o_tlast_q,   o_tlast_d;
    logic             o_tvalid_q,  o_tvalid_d;
    logic             pkt_done_q,  pkt_done_d;

    // Radio framing on i_tlast carries no meaning for packet boundaries.
    logic unused_i_tlast;
    assign unused_i_tlast = i_tlast;

    // ------------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------------
    logic            out_free;
    logic            accept;
    logic            first_smp;
    logic [CP_W-1:0] cp_clamped;
    logic [CP_W-1:0] cp_eff;
    logic [31:0]     pkt_len_eff;
    logic            pkt_end;
    logic            ph_last;
    logic            drop_last;

    // Output register can take a new word this cycle.
    assign out_free = !o_tvalid_q || o_tready;

    always_comb begin
        // NOTE: every path assigns i_tready, so no latch can be inferred.
        i_tready = 1'b0;
        unique case (state_q)
            KEEP:    i_tready = out_free;
            DROP:    i_tready = 1'b1;
            PAD:     i_tready = 1'b0;
            default: i_tready = 1'b0;
        endcase
    end

    assign accept    = i_tvalid && i_tready;
    assign first_smp = (in_cnt_q == '0);

    assign cp_clamped = (32'(cp_len) > MAX_CP_SIZE) ? CP_MAX : CP_W'(cp_len);

    // On a packet's first sample the configuration registers still hold the
    // previous packet's values, so decisions made on that very sample must
    // look at the live inputs instead.
    assign cp_eff      = first_smp ? cp_clamped    : cp_len_q;
    assign pkt_len_eff = first_smp ? packet_length : pkt_len_q;

    assign pkt_end   = (pkt_len_eff != '0) && (in_cnt_q == pkt_len_eff - 32'd1);
    assign ph_last   = (ph_cnt_q == PH_LAST);
    assign drop_last = ((32'(ph_cnt_q) + 32'd1) == 32'(cp_len_q));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset || clear) begin
            state_q <= KEEP;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KEEP: begin
                if (accept) begin
                    if (ph_last) begin
                        // A packet ending on a window boundary skips the CP.
                        state_d = (!pkt_end && (cp_eff != '0)) ? DROP : KEEP;
                    end else if (pkt_end) begin
                        state_d = PAD;
                    end
                end
            end
            DROP: begin
                if (accept && (pkt_end || drop_last)) begin
                    state_d = KEEP;
                end
            end
            PAD: begin
                if (out_free && ph_last) begin
                    state_d = KEEP;
                end
            end
            default: state_d = KEEP;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        ph_cnt_d    = ph_cnt_q;
        in_cnt_d    = in_cnt_q;
        sym_count_d = sym_count_q;
        cp_len_d    = cp_len_q;
        pkt_len_d   = pkt_len_q;
        o_tdata_d   = o_tdata_q;
        o_tlast_d   = o_tlast_q;
        pkt_done_d  = 1'b0;
        // A held word is released once the sink takes it.
        o_tvalid_d  = o_tvalid_q && !o_tready;

        unique case (state_q)
            KEEP: begin
                if (accept) begin
                    o_tdata_d  = i_tdata;
                    o_tlast_d  = ph_last;
                    o_tvalid_d = 1'b1;
                    // sym_count restarts with each packet's first sample.
                    sym_count_d = first_smp ? 16'd0 : sym_count_q;
                    if (ph_last) begin
                        ph_cnt_d    = '0;
                        sym_count_d = sym_count_d + 16'd1;
                        pkt_done_d  = pkt_end;
                    end else begin
                        ph_cnt_d = ph_cnt_q + CNT_W'(1);
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    if (pkt_end || drop_last) begin
                        ph_cnt_d = '0;
                    end else begin
                        ph_cnt_d = ph_cnt_q + CNT_W'(1);
                    end
                    pkt_done_d = pkt_end;
                end
            end
            PAD: begin
                if (out_free) begin
                    o_tdata_d  = '0;
                    o_tlast_d  = ph_last;
                    o_tvalid_d = 1'b1;
                    if (ph_last) begin
                        ph_cnt_d    = '0;
                        sym_count_d = sym_count_q + 16'd1;
                        pkt_done_d  = 1'b1;
                    end else begin
                        ph_cnt_d = ph_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                ph_cnt_d = '0;
            end
        endcase

        // Packet bookkeeping applies to every accepted sample, kept or dropped.
        if (accept) begin
            if (first_smp) begin
                cp_len_d  = cp_clamped;
                pkt_len_d = packet_length;
            end
            if (pkt_end) begin
                in_cnt_d = '0;
            end else if (in_cnt_q != '1) begin
                // Saturates in unbounded mode so in_cnt never returns to 0
                // and the configuration is not re-latched mid-stream.
                in_cnt_d = in_cnt_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ph_cnt_q    <= '0;
            in_cnt_q    <= '0;
            sym_count_q <= '0;
            cp_len_q    <= '0;
            pkt_len_q   <= '0;
            o_tdata_q   <= '0;
            o_tlast_q   <= 1'b0;
            o_tvalid_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            ph_cnt_q    <= ph_cnt_d;
            in_cnt_q    <= in_cnt_d;
            sym_count_q <= sym_count_d;
            cp_len_q    <= cp_len_d;
            pkt_len_q   <= pkt_len_d;
            o_tdata_q   <= o_tdata_d;
            o_tlast_q   <= o_tlast_d;
            o_tvalid_q  <= o_tvalid_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

    assign o_tdata   = o_tdata_q;
    assign o_tlast   = o_tlast_q;
    assign o_tvalid  = o_tvalid_q;
    assign pkt_done  = pkt_done_q;
    assign sym_count = sym_count_q;

endmodule : ofdm_cp_remover

// File: tb/tb_ofdm_cp_remover.sv
// ----------------------------------------------------------------------------
// tb_ofdm_cp_remover
//   Directed and randomized checks of ofdm_cp_remover with FFT_SIZE=8 and
//   MAX_CP_SIZE=4. Expected output is derived from the position of each
//   sample inside its (FFT_SIZE + cp) period within a packet.
// ----------------------------------------------------------------------------
module tb_ofdm_cp_remover;

    localparam int FFT   = 8;
    localparam int MAXCP = 4;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [15:0] cp_len;
    logic [31:0] packet_length;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        pkt_done;
    logic [15:0] sym_count;

    ofdm_cp_remover #(
        .FFT_SIZE    (FFT),
        .MAX_CP_SIZE (MAXCP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .cp_len        (cp_len),
        .packet_length (packet_length),
        .i_tdata       (i_tdata),
        .i_tlast       (i_tlast),
        .i_tvalid      (i_tvalid),
        .i_tready      (i_tready),
        .o_tdata       (o_tdata),
        .o_tlast       (o_tlast),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready),
        .pkt_done      (pkt_done),
        .sym_count     (sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] src [0:127];
    logic [32:0] got_q [$];   // {tlast, tdata} of each output transfer
    logic [32:0] exp_q [$];

    int          sent;
    int          cur_n;
    int          cyc = 0;
    int          last_acc_cyc;
    int          pd_cnt;
    int          pd_cyc;
    int          nrdy;
    logic [33:0] pd_out;
    bit          stall_prev = 1'b0;
    logic [32:0] prev_out;
    int          exp_sym;
    bit          exp_done;
    bit          exp_pad;
    int          exp_pad_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe settled signals just after the falling edge, record
    // what will transfer on the coming rising edge, then wait a full period.
    task automatic cycle();
        #1;
        if (stall_prev) begin
            check("hold_valid", 64'(o_tvalid), 64'd1);
            check("hold_data", 64'({o_tlast, o_tdata}), 64'(prev_out));
        end
        if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tdata});
        if (!i_tready) nrdy++;
        if (i_tvalid && i_tready) begin
            sent++;
            if (sent == cur_n) last_acc_cyc = cyc;
        end
        if (pkt_done) begin
            pd_cnt++;
            pd_cyc = cyc;
            pd_out = {o_tvalid, o_tlast, o_tdata};
        end
        stall_prev = o_tvalid && !o_tready && !reset && !clear;
        prev_out   = {o_tlast, o_tdata};
        cyc++;
        @(negedge clk);
    endtask

    task automatic fill_src(input int n, input bit seq);
        for (int i = 0; i < n; i++) src[i] = seq ? 32'(i + 1) : $urandom;
    endtask

    // Reference: within a packet, sample p sits at offset p % (FFT+cp) of its
    // period; offsets below FFT are kept, offset FFT-1 closes a window. A
    // bounded packet whose last sample lands inside a window is zero-filled.
    task automatic model(input int cp_req, input bit unbounded, input int n);
        int cp;
        int period;
        int k;
        cp = (cp_req > MAXCP) ? MAXCP : cp_req;
        period = FFT + cp;
        exp_q.delete();
        for (int p = 0; p < n; p++) begin
            k = p % period;
            if (k < FFT) exp_q.push_back({k == FFT - 1, src[p]});
        end
        exp_pad   = 1'b0;
        exp_pad_n = 0;
        exp_done  = !unbounded;
        k = (n - 1) % period;
        if (!unbounded && k < FFT - 1) begin
            exp_pad = 1'b1;
            for (int j = k + 1; j < FFT; j++) begin
                exp_q.push_back({j == FFT - 1, 32'h0});
                exp_pad_n++;
            end
        end
        exp_sym = 0;
        foreach (exp_q[i]) if (exp_q[i][32]) exp_sym++;
    endtask

    task automatic run_packet(input int n, input int cp, input int plen, input bit rnd_valid,
                              input int ready_pct, input int chg_after, input int chg_cp);
        int guard;
        got_q.delete();
        sent = 0; cur_n = n; pd_cnt = 0; nrdy = 0;
        last_acc_cyc = -1; pd_cyc = -1; pd_out = '0;
        cp_len = 16'(cp);
        packet_length = 32'(plen);
        guard = 0;
        while (sent < n && guard < 2000) begin
            i_tvalid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_tdata  = src[sent];
            o_tready = ($urandom_range(0, 99) < ready_pct);
            cycle();
            guard++;
            if (sent == chg_after) cp_len = 16'(chg_cp);
        end
        i_tvalid = 1'b0;
        i_tdata  = '0;
        o_tready = 1'b1;
        repeat (20) cycle();

        model(cp, plen == 0, n);
        check("accepted", 64'(sent), 64'(n));
        check("out_count", 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check($sformatf("out[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        check("sym_count", 64'(sym_count), 64'(exp_sym[15:0]));
        check("pkt_done_count", 64'(pd_cnt), exp_done ? 64'd1 : 64'd0);
        if (exp_done && !exp_pad) check("pkt_done_time", 64'(pd_cyc), 64'(last_acc_cyc + 1));
        if (exp_pad) check("pkt_done_on_pad_last", 64'(pd_out), 64'({1'b1, 1'b1, 32'h0}));
        if (ready_pct == 100) check("ready_low_cycles", 64'(nrdy), 64'(exp_pad_n));
        check("idle_after", 64'(o_tvalid), 64'd0);
    endtask

    initial begin
        int n;
        int guard;
        reset = 1'b1; clear = 1'b0; cp_len = '0; packet_length = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_o_tlast", 64'(o_tlast), 64'd0);
        check("rst_o_tdata", 64'(o_tdata), 64'd0);
        check("rst_pkt_done", 64'(pkt_done), 64'd0);
        check("rst_sym_count", 64'(sym_count), 64'd0);
        check("rst_i_tready", 64'(i_tready), 64'd1);

        // Full packet ending inside a CP gap.
        fill_src(30, 1'b1);
        run_packet(30, 2, 30, 1'b0, 100, -1, 0);

        // Packet ending mid-window: three zeros of padding.
        fill_src(25, 1'b1);
        run_packet(25, 2, 25, 1'b0, 100, -1, 0);

        // Back-pressure on the output.
        fill_src(30, 1'b1);
        run_packet(30, 2, 30, 1'b0, 50, -1, 0);

        // No cyclic prefix, then a fresh packet with one.
        fill_src(16, 1'b1);
        run_packet(16, 0, 16, 1'b0, 100, -1, 0);
        fill_src(12, 1'b1);
        run_packet(12, 2, 12, 1'b0, 100, -1, 0);

        // Boundaries: single-sample packet, exact window, first CP sample.
        fill_src(1, 1'b1);
        run_packet(1, 3, 1, 1'b0, 100, -1, 0);
        fill_src(8, 1'b1);
        run_packet(8, 3, 8, 1'b0, 100, -1, 0);
        fill_src(9, 1'b1);
        run_packet(9, 3, 9, 1'b0, 100, -1, 0);

        // cp_len change mid-packet only affects the following packet.
        fill_src(20, 1'b1);
        run_packet(20, 2, 20, 1'b0, 100, 3, 4);
        fill_src(24, 1'b1);
        run_packet(24, 4, 24, 1'b0, 100, -1, 0);

        // cp_len above the maximum is clamped.
        fill_src(26, 1'b0);
        run_packet(26, 9, 26, 1'b0, 100, -1, 0);

        // Reset after five accepted samples, with the fifth still held.
        fill_src(30, 1'b1);
        got_q.delete();
        sent = 0; cur_n = 30;
        cp_len = 16'd2; packet_length = 32'd30; o_tready = 1'b1;
        guard = 0;
        while (sent < 5 && guard < 100) begin
            i_tvalid = 1'b1;
            i_tdata  = src[sent];
            cycle();
            guard++;
        end
        check("pre_reset_accepted", 64'(sent), 64'd5);
        reset = 1'b1; o_tready = 1'b0; i_tvalid = 1'b0;
        cycle();
        reset = 1'b0;
        #1;
        check("mid_reset_transfers", 64'(got_q.size()), 64'd4);
        check("mid_reset_o_tvalid", 64'(o_tvalid), 64'd0);
        check("mid_reset_sym_count", 64'(sym_count), 64'd0);
        fill_src(12, 1'b0);
        run_packet(12, 2, 12, 1'b0, 100, -1, 0);

        // Unbounded stream ending mid-window, flushed by clear.
        fill_src(43, 1'b0);
        run_packet(43, 2, 0, 1'b1, 70, -1, 0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        #1;
        check("clear_o_tvalid", 64'(o_tvalid), 64'd0);
        check("clear_sym_count", 64'(sym_count), 64'd0);
        fill_src(10, 1'b0);
        run_packet(10, 1, 10, 1'b0, 100, -1, 0);

        // Randomized packets with random gaps and back-pressure.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 40);
            fill_src(n, 1'b0);
            run_packet(n, $urandom_range(0, 6), n, 1'b1, 60, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ofdm_cp_remover
